// File: rtl/sgmii_cfg_sequencer.sv
// Bus-master sequencer: programs the SGMII PCS register block after reset,
// then polls status to track link state and capture the partner ability word.
//
// state     | meaning
// IDLE      | parked after reset or ack timeout; boot or i_Start leaves
// WR_MODE   | write reg 0x1F (mode)
// WR_LTLO   | write reg 0x08 (link timer low)
// WR_LTHI   | write reg 0x09 (link timer high)
// WR_REG4   | write reg 0x04 (advertisement)
// WR_REG0   | write reg 0x00 with AN restart bit
// POLL_WAIT | idle countdown between status polls
// RD_STAT   | read reg 0x01 (status)
// RD_LP     | read reg 0x05 (link-partner ability)
// GAP       | one bus-idle cycle after every ack
module sgmii_cfg_sequencer #(
    parameter logic [15:0] pModeReg    = 16'h0001,
    parameter logic [20:0] pLinkTimer  = 21'h0F_4240,
    parameter logic [15:0] pReg4       = 16'h01A0,
    parameter logic [15:0] pReg0       = 16'h1000,
    parameter logic [23:0] pPollCycles = 24'd125000,
    parameter logic [7:0]  pAckTimeout = 8'd16
) (
    input  logic        i_Clk,
    input  logic        i_ARst,
    input  logic        i_Start,
    input  logic        i_ANRestart,
    output logic        o_Cyc,
    output logic        o_Stb,
    output logic        o_WEn,
    output logic [7:0]  o8_Addr,
    output logic [31:0] o32_WrData,
    input  logic [31:0] i32_RdData,
    input  logic        i_Ack,
    input  logic        i_Stall,
    output logic        o_CfgDone,
    output logic        o_LinkUp,
    output logic [15:0] o16_LpAbility,
    output logic        o_Busy,
    output logic        o_BusErr
);

    typedef enum logic [3:0] {
        IDLE, WR_MODE, WR_LTLO, WR_LTHI, WR_REG4, WR_REG0,
        POLL_WAIT, RD_STAT, RD_LP, GAP
    } tSeqState;

    tSeqState    r_State;
    tSeqState    r_NextState;
    logic [23:0] r_PollCnt;
    logic [7:0]  r_AckCnt;
    logic        r_Boot;
    logic        r_AnPend;

    logic        w_Launch;
    tSeqState    w_LaunchState;
    logic        w_Restart;
    logic        unusedBits;

    // Stall is observed by the slave side only; upper read bits carry nothing.
    assign unusedBits = ^{i_Stall, i32_RdData[31:16]};

    // {WEn, Addr, WrData} presented for an access state.
    function automatic logic [40:0] busWord(input tSeqState s);
        busWord = 41'h0;
        case (s)
            WR_MODE: busWord = {1'b1, 8'h7C, 16'h0, pModeReg};
            WR_LTLO: busWord = {1'b1, 8'h20, 16'h0, pLinkTimer[15:0]};
            WR_LTHI: busWord = {1'b1, 8'h24, 16'h0, 11'h0, pLinkTimer[20:16]};
            WR_REG4: busWord = {1'b1, 8'h10, 16'h0, pReg4};
            WR_REG0: busWord = {1'b1, 8'h00, 16'h0, pReg0 | 16'h0200};
            RD_STAT: busWord = {1'b0, 8'h04, 32'h0};
            RD_LP:   busWord = {1'b0, 8'h14, 32'h0};
            default: busWord = 41'h0;
        endcase
    endfunction

    always_comb begin
        w_Launch      = 1'b0;
        w_LaunchState = WR_MODE;
        w_Restart     = 1'b0;
        case (r_State)
            IDLE: begin
                w_Launch  = r_Boot | i_Start;
                w_Restart = r_Boot | i_Start;
            end
            POLL_WAIT: begin
                if (i_Start) begin
                    w_Launch  = 1'b1;
                    w_Restart = 1'b1;
                end else if (r_AnPend) begin
                    w_Launch      = 1'b1;
                    w_LaunchState = WR_REG0;
                end else if (r_PollCnt == 24'd0) begin
                    w_Launch      = 1'b1;
                    w_LaunchState = RD_STAT;
                end
            end
            GAP: begin
                w_Launch      = (r_NextState != POLL_WAIT);
                w_LaunchState = r_NextState;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_ARst) begin
        if (i_ARst) begin
            r_State       <= IDLE;
            r_NextState   <= IDLE;
            r_PollCnt     <= 24'd0;
            r_AckCnt      <= 8'd0;
            r_Boot        <= 1'b1;
            r_AnPend      <= 1'b0;
            o_Cyc         <= 1'b0;
            o_Stb         <= 1'b0;
            o_WEn         <= 1'b0;
            o8_Addr       <= 8'h0;
            o32_WrData    <= 32'h0;
            o_CfgDone     <= 1'b0;
            o_LinkUp      <= 1'b0;
            o16_LpAbility <= 16'h0;
            o_Busy        <= 1'b0;
            o_BusErr      <= 1'b0;
        end else begin
            r_Boot <= 1'b0;

            if (w_Restart)
                r_AnPend <= 1'b0;
            else if (r_State == WR_REG0 && i_Ack)
                r_AnPend <= i_ANRestart;
            else if (i_ANRestart)
                r_AnPend <= 1'b1;

            if (w_Restart) begin
                o_CfgDone <= 1'b0;
                o_LinkUp  <= 1'b0;
                o_BusErr  <= 1'b0;
            end

            if (w_Launch) begin
                r_State  <= w_LaunchState;
                o_Cyc    <= 1'b1;
                o_Stb    <= 1'b1;
                {o_WEn, o8_Addr, o32_WrData} <= busWord(w_LaunchState);
                r_AckCnt <= 8'd1;
                o_Busy   <= 1'b1;
            end

            case (r_State)
                WR_MODE, WR_LTLO, WR_LTHI, WR_REG4, WR_REG0, RD_STAT, RD_LP: begin
                    if (i_Ack) begin
                        o_Cyc   <= 1'b0;
                        o_Stb   <= 1'b0;
                        r_State <= GAP;
                        case (r_State)
                            WR_MODE: r_NextState <= WR_LTLO;
                            WR_LTLO: r_NextState <= WR_LTHI;
                            WR_LTHI: r_NextState <= WR_REG4;
                            WR_REG4: r_NextState <= WR_REG0;
                            WR_REG0: begin
                                o_CfgDone   <= 1'b1;
                                r_NextState <= POLL_WAIT;
                            end
                            RD_STAT: begin
                                if (i32_RdData[5] && i32_RdData[2]) begin
                                    r_NextState <= RD_LP;
                                end else if (o_LinkUp) begin
                                    o_LinkUp    <= 1'b0;
                                    r_NextState <= WR_REG0;
                                end else begin
                                    r_NextState <= POLL_WAIT;
                                end
                            end
                            default: begin
                                o16_LpAbility <= i32_RdData[15:0];
                                o_LinkUp      <= 1'b1;
                                r_NextState   <= POLL_WAIT;
                            end
                        endcase
                    end else if (r_AckCnt >= pAckTimeout) begin
                        o_Cyc     <= 1'b0;
                        o_Stb     <= 1'b0;
                        o_BusErr  <= 1'b1;
                        o_CfgDone <= 1'b0;
                        o_LinkUp  <= 1'b0;
                        o_Busy    <= 1'b0;
                        r_State   <= IDLE;
                    end else if (r_AckCnt != 8'hFF) begin
                        r_AckCnt <= r_AckCnt + 8'd1;
                    end
                end
                GAP: begin
                    if (r_NextState == POLL_WAIT) begin
                        r_State   <= POLL_WAIT;
                        r_PollCnt <= pPollCycles;
                        o_Busy    <= 1'b0;
                    end
                end
                POLL_WAIT: begin
                    if (!w_Launch)
                        r_PollCnt <= r_PollCnt - 24'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sgmii_cfg_sequencer.sv
// Bench for sgmii_cfg_sequencer: edge-detecting slave model, access log,
// table-driven config/poll checks, randomized polls against a link-state model.
module tb_sgmii_cfg_sequencer;

    localparam int F_NONE = 0;
    localparam int F_LP   = 1;
    localparam int F_REG0 = 2;

    logic        i_Clk = 1'b0;
    logic        i_ARst = 1'b1;
    logic        i_Start = 1'b0;
    logic        i_ANRestart = 1'b0;
    logic        o_Cyc, o_Stb, o_WEn;
    logic [7:0]  o8_Addr;
    logic [31:0] o32_WrData;
    logic [31:0] i32_RdData;
    logic        i_Ack = 1'b0;
    logic        i_Stall = 1'b0;
    logic        o_CfgDone, o_LinkUp, o_Busy, o_BusErr;
    logic [15:0] o16_LpAbility;

    sgmii_cfg_sequencer #(.pPollCycles(24'd4)) dut (
        .i_Clk(i_Clk), .i_ARst(i_ARst), .i_Start(i_Start), .i_ANRestart(i_ANRestart),
        .o_Cyc(o_Cyc), .o_Stb(o_Stb), .o_WEn(o_WEn), .o8_Addr(o8_Addr),
        .o32_WrData(o32_WrData), .i32_RdData(i32_RdData), .i_Ack(i_Ack),
        .i_Stall(i_Stall), .o_CfgDone(o_CfgDone), .o_LinkUp(o_LinkUp),
        .o16_LpAbility(o16_LpAbility), .o_Busy(o_Busy), .o_BusErr(o_BusErr)
    );

    always #5 i_Clk = ~i_Clk;

    int nCompared = 0;
    int nMismatched = 0;
    int cycleNum = 0;
    int stbBad = 0;

    // Slave: ack one cycle after a Stb rising edge, unless reg4 is blocked.
    logic [15:0] statusVal = 16'h0;
    logic [15:0] lpVal = 16'h0;
    logic        noAck = 1'b0;
    logic        stbPrev = 1'b0;
    always @(posedge i_Clk) begin
        i_Ack   <= o_Stb && !stbPrev && !(noAck && o8_Addr == 8'h10);
        stbPrev <= o_Stb;
    end
    assign i32_RdData = (o8_Addr == 8'h04) ? {16'hDEAD, statusVal} :
                        (o8_Addr == 8'h14) ? {16'hBEEF, lpVal} : 32'hFFFF_FFFF;

    always @(posedge i_Clk or posedge i_ARst)
        if (i_ARst) cycleNum <= 0;
        else        cycleNum <= cycleNum + 1;

    typedef struct {
        logic        wen;
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } access_t;

    access_t accLog[$];
    logic    prevCyc = 1'b0;
    always @(negedge i_Clk) begin
        if (o_Cyc && !prevCyc)
            accLog.push_back('{o_WEn, o8_Addr, o32_WrData, cycleNum});
        if (o_Stb !== o_Cyc)
            stbBad <= stbBad + 1;
        prevCyc <= o_Cyc;
    end

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } cfg_t;
    cfg_t cfgTab[5];

    typedef struct {
        logic [15:0] status;
        logic [15:0] lp;
        logic        expLink;
        logic [15:0] expLp;
        int          follow;
    } poll_t;
    poll_t pollTab[7];

    logic        curLink = 1'b0;
    logic [15:0] curLp = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleNum);
        end
    endtask

    task automatic waitCycle(input int n);
        int guard = 0;
        while (cycleNum < n && guard < 1000) begin
            @(negedge i_Clk);
            guard++;
        end
        if (cycleNum != n) begin
            nCompared++;
            nMismatched++;
            $display("FAIL wait_cycle: at cycle %0d, wanted %0d", cycleNum, n);
        end
    endtask

    task automatic nextAccess(output access_t r);
        int guard = 0;
        while (accLog.size() == 0 && guard < 400) begin
            @(negedge i_Clk);
            guard++;
        end
        if (accLog.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL access_timeout: no bus access by cycle %0d", cycleNum);
            r = '{1'b0, 8'hEE, 32'h0, cycleNum};
        end else begin
            r = accLog.pop_front();
        end
    endtask

    task automatic expectAccess(input string name, input logic wen, input logic [7:0] addr,
                                input logic [31:0] data, output access_t r);
        nextAccess(r);
        check({name, "_addr"}, 32'(r.addr), 32'(addr));
        check({name, "_wen"}, 32'(r.wen), 32'(wen));
        if (wen)
            check({name, "_data"}, r.data, data);
    endtask

    // Full five-write configuration starting at cycle startCyc; optional i_Start during WR_LTLO.
    task automatic checkConfig(input int startCyc, input bit injectStart);
        access_t r;
        for (int i = 0; i < 5; i++) begin
            expectAccess($sformatf("cfg%0d", i), 1'b1, cfgTab[i].addr, cfgTab[i].data, r);
            check($sformatf("cfg%0d_cycle", i), 32'(r.cyc), 32'(startCyc + 3 * i));
            if (injectStart && i == 1) begin
                waitCycle(r.cyc + 1);
                i_Start = 1'b1;
                @(negedge i_Clk);
                i_Start = 1'b0;
            end
        end
        waitCycle(r.cyc + 1);
        check("cfgdone_before_ack", 32'(o_CfgDone), 32'(0));
        waitCycle(r.cyc + 2);
        check("cfgdone_at_ack", 32'(o_CfgDone), 32'(1));
    endtask

    task automatic pollStep(input logic [15:0] st, input logic [15:0] lp, input logic expLink,
                            input logic [15:0] expLp, input int follow);
        access_t r, r2;
        statusVal = st;
        lpVal = lp;
        expectAccess("stat", 1'b0, 8'h04, 32'h0, r);
        waitCycle(r.cyc + 1);
        check("link_before_stat_ack", 32'(o_LinkUp), 32'(curLink));
        waitCycle(r.cyc + 2);
        if (follow == F_LP) begin
            check("link_at_stat_ack", 32'(o_LinkUp), 32'(curLink));
            expectAccess("lp", 1'b0, 8'h14, 32'h0, r2);
            check("lp_cycle", 32'(r2.cyc), 32'(r.cyc + 3));
            waitCycle(r2.cyc + 1);
            check("link_before_lp_ack", 32'(o_LinkUp), 32'(curLink));
            check("lpab_before_lp_ack", 32'(o16_LpAbility), 32'(curLp));
            waitCycle(r2.cyc + 2);
            check("link_at_lp_ack", 32'(o_LinkUp), 32'(expLink));
            check("lpab_at_lp_ack", 32'(o16_LpAbility), 32'(expLp));
        end else begin
            check("link_at_stat_ack", 32'(o_LinkUp), 32'(expLink));
            if (follow == F_REG0) begin
                expectAccess("restart_reg0", 1'b1, 8'h00, 32'h0000_1200, r2);
                check("restart_cycle", 32'(r2.cyc), 32'(r.cyc + 3));
            end
        end
        curLink = expLink;
        curLp = expLp;
    endtask

    // Link-state model: good status fetches the partner word; loss of a good link forces AN restart.
    task automatic modelPoll(input logic [15:0] st, input logic [15:0] lp);
        bit good = ((st & 16'h0024) == 16'h0024);
        if (good)
            pollStep(st, lp, 1'b1, lp, F_LP);
        else if (curLink)
            pollStep(st, lp, 1'b0, curLp, F_REG0);
        else
            pollStep(st, lp, 1'b0, curLp, F_NONE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycleNum);
        $fatal(1, "watchdog");
    end

    initial begin
        access_t r, r2, r3;
        int s;

        cfgTab[0] = '{8'h7C, 32'h0000_0001};
        cfgTab[1] = '{8'h20, 32'h0000_4240};
        cfgTab[2] = '{8'h24, 32'h0000_000F};
        cfgTab[3] = '{8'h10, 32'h0000_01A0};
        cfgTab[4] = '{8'h00, 32'h0000_1200};

        pollTab[0] = '{16'h0000, 16'h1111, 1'b0, 16'h0000, F_NONE};
        pollTab[1] = '{16'h0034, 16'hD801, 1'b1, 16'hD801, F_LP};
        pollTab[2] = '{16'h0034, 16'h1234, 1'b1, 16'h1234, F_LP};
        pollTab[3] = '{16'h0010, 16'h2222, 1'b0, 16'h1234, F_REG0};
        pollTab[4] = '{16'h0020, 16'h3333, 1'b0, 16'h1234, F_NONE};
        pollTab[5] = '{16'hFF24, 16'hABCD, 1'b1, 16'hABCD, F_LP};
        pollTab[6] = '{16'h0004, 16'h4444, 1'b0, 16'hABCD, F_REG0};

        repeat (3) @(negedge i_Clk);
        check("rst_cyc", 32'(o_Cyc), 32'(0));
        check("rst_stb", 32'(o_Stb), 32'(0));
        check("rst_wen", 32'(o_WEn), 32'(0));
        check("rst_addr", 32'(o8_Addr), 32'(0));
        check("rst_wrdata", o32_WrData, 32'h0);
        check("rst_lpab", 32'(o16_LpAbility), 32'(0));
        check("rst_flags", 32'({o_CfgDone, o_LinkUp, o_Busy, o_BusErr}), 32'(0));
        i_ARst = 1'b0;

        checkConfig(1, 1'b0);

        for (int i = 0; i < 7; i++)
            pollStep(pollTab[i].status, pollTab[i].lp, pollTab[i].expLink,
                     pollTab[i].expLp, pollTab[i].follow);

        for (int i = 0; i < 24; i++) begin
            logic [15:0] st;
            st = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) st = st | 16'h0024;
            modelPoll(st, 16'($urandom));
        end

        // AN restart request arriving while a status read is in flight.
        modelPoll(16'h0010, 16'h0);
        statusVal = 16'h0000;
        expectAccess("anr_stat", 1'b0, 8'h04, 32'h0, r);
        waitCycle(r.cyc + 1);
        i_ANRestart = 1'b1;
        @(negedge i_Clk);
        i_ANRestart = 1'b0;
        check("anr_link", 32'(o_LinkUp), 32'(0));
        expectAccess("anr_reg0", 1'b1, 8'h00, 32'h0000_1200, r2);
        expectAccess("anr_then_stat", 1'b0, 8'h04, 32'h0, r3);

        // i_Start from POLL_WAIT, then a second i_Start during WR_LTLO which must be ignored.
        waitCycle(r3.cyc + 3);
        check("poll_busy", 32'(o_Busy), 32'(0));
        check("poll_cfgdone", 32'(o_CfgDone), 32'(1));
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        check("start_clears_cfgdone", 32'(o_CfgDone), 32'(0));
        check("start_busy", 32'(o_Busy), 32'(1));
        curLink = 1'b0;
        checkConfig(r3.cyc + 4, 1'b1);

        // Ack timeout on WR_REG4.
        waitCycle(cycleNum + 1);
        noAck = 1'b1;
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        for (int i = 0; i < 4; i++)
            expectAccess($sformatf("to_cfg%0d", i), 1'b1, cfgTab[i].addr, cfgTab[i].data, r);
        waitCycle(r.cyc + 15);
        check("to_cyc_held", 32'(o_Cyc), 32'(1));
        check("to_buserr_before", 32'(o_BusErr), 32'(0));
        waitCycle(r.cyc + 16);
        check("to_cyc_dropped", 32'(o_Cyc), 32'(0));
        check("to_buserr", 32'(o_BusErr), 32'(1));
        check("to_busy", 32'(o_Busy), 32'(0));
        check("to_cfgdone", 32'(o_CfgDone), 32'(0));
        repeat (40) @(negedge i_Clk);
        check("to_no_activity", 32'(accLog.size()), 32'(0));
        check("to_idle_cyc", 32'(o_Cyc), 32'(0));
        noAck = 1'b0;
        s = cycleNum + 1;
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        check("start_clears_buserr", 32'(o_BusErr), 32'(0));
        checkConfig(s, 1'b0);
        modelPoll(16'h0034, 16'h5A5A);

        // Reset in the middle of a status read.
        statusVal = 16'h0034;
        expectAccess("rst_stat", 1'b0, 8'h04, 32'h0, r);
        waitCycle(r.cyc + 1);
        check("pre_rst_cyc", 32'(o_Cyc), 32'(1));
        check("pre_rst_link", 32'(o_LinkUp), 32'(1));
        #2 i_ARst = 1'b1;
        #1;
        check("midrst_cyc_stb", 32'({o_Cyc, o_Stb}), 32'(0));
        check("midrst_flags", 32'({o_CfgDone, o_LinkUp, o_Busy, o_BusErr}), 32'(0));
        check("midrst_lpab", 32'(o16_LpAbility), 32'(0));
        repeat (2) @(negedge i_Clk);
        accLog.delete();
        curLink = 1'b0;
        curLp = 16'h0;
        i_ARst = 1'b0;
        checkConfig(1, 1'b0);
        modelPoll(16'h0000, 16'h0);

        check("stb_follows_cyc", 32'(stbBad), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sgmii_cfg_sequencer.md
# sgmii_cfg_sequencer

Bus-master sequencer that brings up and supervises the SGMII/1000BASE-X PCS through its register-file bus port (Cyc/Stb/WEn, byte address, Ack/Stall). After reset it programs the mode register, link timer, advertisement register and control register 0. It then polls status register 1 periodically, reports link state and captures the link-partner ability word. It sits between the system reset/management logic and the PCS register block, and replaces software bring-up.

## Interface
- pModeReg, 16'h0001: value written to register 0x1F (bit0 SGMII, bit1 PHY side, bit2 use local config).
- pLinkTimer, 21'h0F_4240: link timer; bits [15:0] go to reg 0x08, bits [20:16] go to reg 0x09.
- pReg4, 16'h01A0: advertisement value written to reg 0x04.
- pReg0, 16'h1000: control value written to reg 0x00; the sequencer always ORs in bit9 (AN restart).
- pPollCycles, 24'd125000: idle cycles between status polls; 0 means back-to-back.
- pAckTimeout, 8'd16: cycles allowed for Ack per access.
- i_Clk  in  1  clock, shared with the register block.
- i_ARst  in  1  reset, asynchronous, active-high.
- i_Start  in  1  one-cycle pulse; re-runs the full configuration when the block is not busy.
- i_ANRestart  in  1  one-cycle pulse; requests a reg0 write (with bit9 set) at the next access boundary.
- o_Cyc, o_Stb  out  1  bus cycle/strobe; always driven equal.
- o_WEn  out  1  1 = write.
- o8_Addr  out  8  byte address, equal to register index × 4.
- o32_WrData  out  32  {16'h0, value}.
- i32_RdData  in  32  read data; valid in the cycle i_Ack = 1.
- i_Ack  in  1  access acknowledge.
- i_Stall  in  1  ignored for sequencing; monitored only.
- o_CfgDone  out  1  high once all five configuration writes have been acked.
- o_LinkUp  out  1  high when the last status read had AN complete and sync both set.
- o16_LpAbility  out  16  last link-partner ability read (reg 0x05).
- o_Busy  out  1  high in any state other than IDLE and POLL_WAIT.
- o_BusErr  out  1  sticky Ack-timeout flag; cleared by reset or i_Start.

## Operation
- States: IDLE, WR_MODE (0x7C), WR_LTLO (0x20), WR_LTHI (0x24), WR_REG4 (0x10), WR_REG0 (0x00), POLL_WAIT, RD_STAT (0x04), RD_LP (0x14), GAP.
- After reset release, the block enters WR_MODE automatically on the first clock edge.
- Config order: WR_MODE → WR_LTLO → WR_LTHI → WR_REG4 → WR_REG0.
- WR_LTHI data is {11'h0, pLinkTimer[20:16]}. WR_REG0 data is pReg0 | 16'h0200.
- After the WR_REG0 ack, o_CfgDone is set and the block enters POLL_WAIT.
- POLL_WAIT loads its counter to pPollCycles on entry and goes to RD_STAT when the count reaches 0.
- RD_STAT outcome:
  - Status bit5 (AN complete) and bit2 (sync) both 1: go to RD_LP. On the RD_LP ack, latch o16_LpAbility, set o_LinkUp, return to POLL_WAIT.
  - Either bit 0 while o_LinkUp = 1: clear o_LinkUp, go to WR_REG0 (AN restart), then POLL_WAIT.
  - Otherwise: return to POLL_WAIT.
- i_ANRestart is latched into a pending flag. It is serviced from POLL_WAIT (go to WR_REG0) and cleared when that write is acked.
- i_Start from IDLE or POLL_WAIT:
  - clears o_CfgDone, o_LinkUp and o_BusErr;
  - drops any pending restart;
  - goes to WR_MODE.
  - i_Start in any other state is ignored.
- Ack timeout: if no i_Ack within pAckTimeout cycles of Cyc rising, the block deasserts Cyc/Stb, sets o_BusErr, clears o_CfgDone and o_LinkUp, and goes to IDLE. Only i_Start leaves IDLE.

## Timing
- Reset values: o_Cyc = o_Stb = o_WEn = 0, o8_Addr = 0, o32_WrData = 0, o16_LpAbility = 0, all flags 0. Internal state is IDLE while reset is held.
- All outputs are registered. Cyc, Stb, WEn, address and data change only together and stay stable until the Ack.
- Access cycle: Cyc/Stb rise at edge E. The register block acks at E+1.
- On the edge where i_Ack = 1 is sampled:
  - read data is captured;
  - Cyc/Stb fall;
  - the block enters GAP for exactly one cycle, so the slave's edge detector re-arms.
- Best-case access is 3 cycles. Full configuration completes 15 cycles after reset release.
- o_LinkUp and o16_LpAbility update on the same edge as the RD_LP Ack. o_LinkUp clears on the RD_STAT Ack edge.
- Timeout counter is 8 bits and saturates. A timeout with pAckTimeout = 0 fires on the first wait cycle.
- Reset asserted mid-access: the bus drops immediately (asynchronously). The sequence restarts from WR_MODE after release.

## Test plan
- Reset release, responsive slave model (Ack one cycle after Stb edge) → write sequence is addr/data 0x7C/0x0001, 0x20/0x4240, 0x24/0x000F, 0x10/0x01A0, 0x00/0x1200; o_CfgDone = 1 at cycle 15; one idle cycle between every pair of accesses.
- pPollCycles = 4, status read returns 0x0034, then reg5 returns 0xD801 → RD_LP issued; o_LinkUp = 1 and o16_LpAbility = 0xD801 on the same edge.
- Link up, status then returns 0x0010 → o_LinkUp = 0 at that Ack; next access is write 0x00/0x1200; polling resumes.
- Slave never acks in WR_REG4 → Cyc drops 16 cycles after rising; o_BusErr = 1; IDLE; no further bus activity until i_Start, which restarts at 0x7C and clears o_BusErr.
- i_ANRestart pulse during RD_STAT → that read completes normally; the next access after POLL_WAIT is write 0x00/0x1200. i_Start pulse during WR_LTLO → ignored, sequence unchanged.
- i_ARst asserted while Cyc = 1 → Cyc, Stb and all flags are 0 in the same cycle; after release, the full write sequence repeats from 0x7C.
